// File: rtl/mult_div_unit_pkg.sv
// Shared MDop encodings, default latencies and controller state type for the
// multiply/divide unit; the hazard unit imports the same constants.
package mult_div_unit_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Bits [1:0] of an arithmetic MDop: bit 1 selects divide, bit 0 unsigned.
  function automatic logic md_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational 32x32 multiply / divide datapath producing {hi,lo} and a
// divide-by-zero flag; the parent samples the result on the launch edge.
module md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [1:0]  i_op,
  output logic [63:0] o_result,
  output logic        o_div0
);

  logic        w_is_div;
  logic        w_uns;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_product;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_is_div = i_op[1];
  assign w_uns    = i_op[0];

  // Low 64 bits of the extended product are exact for both signednesses.
  assign w_a_ext   = {{32{i_a[31] & ~w_uns}}, i_a};
  assign w_b_ext   = {{32{i_b[31] & ~w_uns}}, i_b};
  assign w_product = w_a_ext * w_b_ext;

  // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign w_a_neg  = ~w_uns & i_a[31];
  assign w_b_neg  = ~w_uns & i_b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_b_mag  = w_b_neg ? (32'd0 - i_b) : i_b;
  assign o_div0   = w_is_div & (i_b == '0);
  assign w_b_safe = (i_b == '0) ? 32'd1 : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;
  assign w_quot   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  assign o_result = w_is_div ? {w_rem, w_quot} : w_product;

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, runs a fixed-latency countdown
// per operation and raises Busy so later HI/LO users can be stalled.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDop,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_phi;
  logic [31:0]      r_plo;
  logic             r_div0;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0]      w_result;
  logic             w_div0;
  md_op_e           w_op;

  assign w_op = md_op_e'(MDop);

  md_arith u_arith (
    .i_a      (A),
    .i_b      (B),
    .i_op     (MDop[1:0]),
    .o_result (w_result),
    .o_div0   (w_div0)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_div0  <= 1'b0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            if (md_is_arith(MDop)) begin
              r_phi   <= w_result[63:32];
              r_plo   <= w_result[31:0];
              r_div0  <= w_div0;
              r_cnt   <= MDop[1] ? DIV_LOAD : MULT_LOAD;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              case (w_op)
                MD_MTHI: r_hi <= A;
                MD_MTLO: r_lo <= A;
                default: ;
              endcase
            end
          end
        end
        ST_RUN: begin
          // Start is deliberately not examined here: the hazard unit stalls on Busy|Start.
          if (r_cnt == '0) begin
            if (!r_div0) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, Busy spans,
// ignored starts while running, divide-by-zero and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDop;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_vec;
  int n_bad;
  int cyc;
  int t0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDop  (MDop),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Drive a one-cycle Start over the next rising edge; returns #1 after it.
  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; MDop = op; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDop = 3'd7;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (Busy !== 1'b0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    A = '0; B = '0; MDop = 3'd7; Start = 1'b0;
    reset = 1'b1;
    #1;
    chk("reset_busy", {31'd0, Busy}, 32'd0);
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    #22 reset = 1'b0;
    step(1);

    // signed mult -1 * 2
    pulse(MD_MULT, 32'hFFFFFFFF, 32'h00000002);
    t0 = cyc;
    chk("mult_busy_set", {31'd0, Busy}, 32'd1);
    wait_idle();
    chk("mult_span", cyc - t0, 32'd5);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);

    pulse(MD_MULTU, 32'hFFFFFFFF, 32'h00000002);
    t0 = cyc;
    wait_idle();
    chk("multu_span", cyc - t0, 32'd5);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    pulse(MD_DIV, 32'hFFFFFFF9, 32'h00000002);
    t0 = cyc;
    step(9);
    chk("div_busy_late", {31'd0, Busy}, 32'd1);
    chk("div_hi_not_yet", HI, 32'h00000001);
    wait_idle();
    chk("div_span", cyc - t0, 32'd10);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    pulse(MD_DIVU, 32'h00000007, 32'h00000002);
    wait_idle();
    chk("divu_lo", LO, 32'h00000003);
    chk("divu_hi", HI, 32'h00000001);

    pulse(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    chk("div_ovf_lo", LO, 32'h80000000);
    chk("div_ovf_hi", HI, 32'h00000000);

    // mthi/mtlo preload, then divide by zero leaves them intact
    pulse(MD_MTHI, 32'h11111111, 32'hDEADBEEF);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    pulse(MD_MTLO, 32'h22222222, 32'hDEADBEEF);
    chk("mthi_hi", HI, 32'h11111111);
    chk("mtlo_lo", LO, 32'h22222222);
    pulse(MD_DIVU, 32'h00000055, 32'h00000000);
    t0 = cyc;
    wait_idle();
    chk("div0_span", cyc - t0, 32'd10);
    chk("div0_hi", HI, 32'h11111111);
    chk("div0_lo", LO, 32'h22222222);

    pulse(3'd6, 32'hAAAAAAAA, 32'hBBBBBBBB);
    chk("nop_busy", {31'd0, Busy}, 32'd0);
    chk("nop_hi", HI, 32'h11111111);

    pulse(MD_MTHI, 32'h12345678, 32'h0);
    chk("mthi_idle_hi", HI, 32'h12345678);
    chk("mthi_idle_busy", {31'd0, Busy}, 32'd0);

    // mthi during a running mult is ignored
    pulse(MD_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
    t0 = cyc;
    pulse(MD_MTHI, 32'hCAFEF00D, 32'h0);
    chk("mthi_run_hi", HI, 32'h12345678);
    wait_idle();
    chk("mthi_run_span", cyc - t0, 32'd5);
    chk("mthi_run_hi_end", HI, 32'h3FFFFFFF);
    chk("mthi_run_lo_end", LO, 32'h00000001);

    // divu started during a mult is ignored
    pulse(MD_MULT, 32'h00000003, 32'h00000005);
    t0 = cyc;
    step(1);
    pulse(MD_DIVU, 32'h00000064, 32'h00000007);
    wait_idle();
    chk("ign_divu_span", cyc - t0, 32'd5);
    chk("ign_divu_hi", HI, 32'h00000000);
    chk("ign_divu_lo", LO, 32'h0000000F);
    step(12);
    chk("ign_divu_busy_after", {31'd0, Busy}, 32'd0);
    chk("ign_divu_lo_after", LO, 32'h0000000F);

    // async reset mid-divide aborts without a later commit
    pulse(MD_DIV, 32'h00000064, 32'h00000007);
    step(3);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
    chk("rst_mid_hi", HI, 32'h0);
    chk("rst_mid_lo", LO, 32'h0);
    #9 reset = 1'b0;
    step(12);
    chk("rst_after_busy", {31'd0, Busy}, 32'd0);
    chk("rst_after_lo", LO, 32'h0);
    chk("rst_after_hi", HI, 32'h0);

    pulse(MD_MULT, 32'h00010000, 32'h00010000);
    t0 = cyc;
    wait_idle();
    chk("post_rst_span", cyc - t0, 32'd5);
    chk("post_rst_hi", HI, 32'h00000001);
    chk("post_rst_lo", LO, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
